memoria_programa: RTL and testbench

Parametrised instruction memory for the MIPS datapath that is loaded at run time from the debug unit instead of a fixed initial image. It accepts a big-endian byte stream, packs it into words, then serves registered instruction fetches to the IF stage. It also flags halt words, misaligned PCs and out-of-range PCs. It replaces the fixed-image instruction memory in the IF stage.

---
 rtl/mips_pkg.sv | 19 +
 rtl/empaquetador_bytes.sv | 48 ++++
 rtl/memoria_programa.sv | 124 ++++++++++++
 tb/tb_memoria_programa.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: special instruction words,
// the program-memory state encoding and an address-width helper.
package mips_pkg;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Word-index width for a memory of the given depth (at least one bit).
  function automatic int idx_width(input int celdas);
    return (celdas > 1) ? $clog2(celdas) : 1;
  endfunction

endpackage

// File: rtl/empaquetador_bytes.sv
// Byte-to-word packer: shifts in big-endian bytes and strobes word_valid
// combinationally on the byte that completes a word.
module empaquetador_bytes #(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic             i_accept,
  input  logic [7:0]       i_byte,
  output logic [NBITS-1:0] o_word,
  output logic             o_word_valid
);

  localparam int NB   = NBITS / 8;
  localparam int CNTW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(NB - 1);

  logic [NBITS-9:0] shift_q, shift_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  // The current byte is the LSB of the word being assembled.
  assign o_word       = {shift_q, i_byte};
  assign o_word_valid = i_accept && (cnt_q == LAST);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (i_clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (i_accept) begin
      shift_d = o_word[NBITS-9:0];
      cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/memoria_programa.sv
// Run-time loadable instruction memory: packs a byte stream from the debug
// unit into words, then serves registered fetches with halt/fault flags.
module memoria_programa #(
  parameter int               NBITS     = 32,
  parameter int               CELDAS    = 64,
  parameter logic [NBITS-1:0] HALT_WORD = NBITS'(mips_pkg::HALT_WORD)
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset_n,
  input  logic                                  i_load_start,
  input  logic                                  i_load_valid,
  input  logic [7:0]                            i_load_byte,
  output logic                                  o_load_ready,
  output logic                                  o_load_done,
  output logic [mips_pkg::idx_width(CELDAS):0]  o_word_count,
  input  logic                                  i_run,
  input  logic                                  i_enable,
  input  logic [NBITS-1:0]                      i_PC,
  output logic [NBITS-1:0]                      o_Instruction,
  output logic                                  o_halt,
  output logic                                  o_fault,
  output logic [1:0]                            o_state
);

  localparam int AW = mips_pkg::idx_width(CELDAS);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    DEPTH    = CW'(CELDAS);
  localparam logic [NBITS-1:0] PC_LIMIT = NBITS'(4 * CELDAS);
  localparam logic [NBITS-1:0] NOP      = NBITS'(mips_pkg::NOP_WORD);

  mips_pkg::state_t  state_q;
  logic [CW-1:0]     wptr_q, count_q;
  logic              ready_q, done_q;
  logic [NBITS-1:0]  instr_q;
  logic              fault_q;
  logic [NBITS-1:0]  mem_q [CELDAS];

  logic              accept, word_valid, wr_en, load_end, pc_bad;
  logic [NBITS-1:0]  packed_word;
  logic [CW-1:0]     wptr_inc;
  logic [AW-1:0]     rd_idx;

  // Load handshake: a byte moves when i_load_valid && o_load_ready are both
  // high on a rising edge; a byte offered together with i_load_start is dropped.
  assign accept   = (state_q == mips_pkg::ST_LOAD) && ready_q && i_load_valid && !i_load_start;
  assign wr_en    = accept && word_valid;
  assign wptr_inc = wptr_q + 1'b1;
  assign load_end = wr_en && ((packed_word == HALT_WORD) || (wptr_inc == DEPTH));
  assign rd_idx   = i_PC[AW+1:2];
  assign pc_bad   = (i_PC[1:0] != 2'b00) || (i_PC >= PC_LIMIT);

  empaquetador_bytes #(.NBITS(NBITS)) u_empaquetador (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_clear      (i_load_start),
    .i_accept     (accept),
    .i_byte       (i_load_byte),
    .o_word       (packed_word),
    .o_word_valid (word_valid)
  );

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= packed_word;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= mips_pkg::ST_IDLE;
      wptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      instr_q <= NOP;
      fault_q <= 1'b0;
    end else if (i_load_start) begin
      // Any state restarts the load, dropping a pending partial word.
      state_q <= mips_pkg::ST_LOAD;
      wptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      instr_q <= NOP;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        mips_pkg::ST_IDLE: begin
          instr_q <= NOP;
          fault_q <= 1'b0;
          if (i_run) state_q <= mips_pkg::ST_RUN;
        end
        mips_pkg::ST_LOAD: begin
          instr_q <= NOP;
          fault_q <= 1'b0;
          if (wr_en) begin
            wptr_q  <= wptr_inc;
            count_q <= wptr_inc;
            if (load_end) begin
              done_q  <= 1'b1;
              ready_q <= 1'b0;
              state_q <= mips_pkg::ST_IDLE;
            end
          end
        end
        mips_pkg::ST_RUN: begin
          if (i_enable) begin
            instr_q <= pc_bad ? NOP : mem_q[rd_idx];
            fault_q <= pc_bad;
          end
        end
        default: state_q <= mips_pkg::ST_IDLE;
      endcase
    end
  end

  assign o_load_ready  = ready_q;
  assign o_load_done   = done_q;
  assign o_word_count  = count_q;
  assign o_Instruction = instr_q;
  assign o_fault       = fault_q;
  assign o_halt        = (instr_q == HALT_WORD);
  assign o_state       = state_q;

endmodule

// File: tb/tb_memoria_programa.sv
// Self-checking bench for memoria_programa: a byte-stream/fetch driver feeds a
// behavioural memory model; a monitor pops expected fetch results and compares.
module tb_memoria_programa;

  localparam int NBITS  = 32;
  localparam int CELDAS = 64;
  localparam int CW     = $clog2(CELDAS) + 1;
  localparam int W      = NBITS + 2;
  localparam logic [NBITS-1:0] HALT = 32'hFFFF_FFFF;

  logic             i_clk, i_reset_n, i_load_start, i_load_valid, i_run, i_enable;
  logic [7:0]       i_load_byte;
  logic [NBITS-1:0] i_PC;
  logic             o_load_ready, o_load_done, o_halt, o_fault;
  logic [CW-1:0]    o_word_count;
  logic [NBITS-1:0] o_Instruction;
  logic [1:0]       o_state;

  memoria_programa #(.NBITS(NBITS), .CELDAS(CELDAS)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_load_start(i_load_start),
    .i_load_valid(i_load_valid), .i_load_byte(i_load_byte),
    .o_load_ready(o_load_ready), .o_load_done(o_load_done),
    .o_word_count(o_word_count), .i_run(i_run), .i_enable(i_enable),
    .i_PC(i_PC), .o_Instruction(o_Instruction), .o_halt(o_halt),
    .o_fault(o_fault), .o_state(o_state)
  );

  // Clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard state and reference model
  int               checks = 0;
  int               failures = 0;
  logic [W-1:0]     exp_q[$];
  logic             chk_en = 1'b0;
  logic [W-1:0]     mon_e;
  logic [NBITS-1:0] model_mem [CELDAS];
  bit               model_def [CELDAS];
  logic [NBITS-1:0] model_instr;
  logic             model_fault;
  int               model_wc;
  bit               model_done;
  logic [7:0]       pack_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every edge flagged by the driver carries one expected fetch result.
  initial begin
    forever begin
      @(posedge i_clk);
      if (chk_en) begin
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fetch_underflow: got output %0h expected queue entry none", o_Instruction);
        end else begin
          mon_e = exp_q.pop_front();
          check("fetch", 64'({o_Instruction, o_fault, o_halt}), 64'(mon_e));
        end
      end
    end
  end

  // Driver tasks
  task automatic model_reset_outputs();
    model_instr = '0;
    model_fault = 1'b0;
  endtask

  task automatic start_load();
    @(negedge i_clk);
    chk_en = 1'b0;
    i_enable = 1'b0;
    i_load_valid = 1'b0;
    i_load_start = 1'b1;
    @(negedge i_clk);
    i_load_start = 1'b0;
    model_wc = 0;
    model_done = 1'b0;
    pack_q.delete();
    model_reset_outputs();
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [NBITS-1:0] w;
    @(negedge i_clk);
    i_load_valid = 1'b0;
    if ($urandom_range(0, 3) == 0) @(negedge i_clk);
    i_load_valid = 1'b1;
    i_load_byte = b;
    if (!model_done) begin
      pack_q.push_back(b);
      if (pack_q.size() == NBITS / 8) begin
        w = {pack_q[0], pack_q[1], pack_q[2], pack_q[3]};
        pack_q.delete();
        model_mem[model_wc] = w;
        model_def[model_wc] = 1'b1;
        model_wc++;
        if (w == HALT || model_wc == CELDAS) model_done = 1'b1;
      end
    end
  endtask

  task automatic send_word(input logic [NBITS-1:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
  endtask

  task automatic end_load();
    @(negedge i_clk);
    i_load_valid = 1'b0;
  endtask

  task automatic start_run();
    @(negedge i_clk);
    chk_en = 1'b0;
    i_run = 1'b1;
    @(negedge i_clk);
    i_run = 1'b0;
  endtask

  task automatic fetch(input logic [NBITS-1:0] pc, input logic en);
    @(negedge i_clk);
    i_PC = pc;
    i_enable = en;
    chk_en = 1'b1;
    if (en) begin
      if ((pc % 4) != 0 || pc >= 4 * CELDAS) begin
        model_instr = '0;
        model_fault = 1'b1;
      end else begin
        model_instr = model_mem[pc / 4];
        model_fault = 1'b0;
      end
    end
    exp_q.push_back({model_instr, model_fault, model_instr == HALT});
  endtask

  task automatic fetch_end();
    @(negedge i_clk);
    chk_en = 1'b0;
    i_enable = 1'b0;
  endtask

  function automatic logic [NBITS-1:0] rand_pc();
    int idx;
    case ($urandom_range(0, 3))
      0, 1: begin
        idx = $urandom_range(0, CELDAS - 1);
        while (!model_def[idx]) idx = $urandom_range(0, CELDAS - 1);
        return NBITS'(idx * 4);
      end
      2: return NBITS'($urandom_range(0, CELDAS - 1) * 4 + $urandom_range(1, 3));
      default: return NBITS'(4 * CELDAS + $urandom_range(0, 4000));
    endcase
  endfunction

  task automatic random_fetches(input int n);
    for (int k = 0; k < n; k++) fetch(rand_pc(), $urandom_range(0, 3) != 0);
  endtask

  task automatic check_load(input string tag, input int wc, input logic done, input logic rdy);
    check({tag, "_word_count"}, 64'(o_word_count), 64'(wc));
    check({tag, "_load_done"}, 64'(o_load_done), 64'(done));
    check({tag, "_load_ready"}, 64'(o_load_ready), 64'(rdy));
    check({tag, "_instr_zero"}, 64'(o_Instruction), 64'(0));
  endtask

  // Main stimulus
  initial begin
    logic [NBITS-1:0] w;
    for (int k = 0; k < CELDAS; k++) model_def[k] = 1'b0;
    model_reset_outputs();
    model_wc = 0;
    model_done = 1'b0;
    i_reset_n = 1'b0; i_load_start = 1'b0; i_load_valid = 1'b0; i_load_byte = '0;
    i_run = 1'b0; i_enable = 1'b0; i_PC = '0;
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    check_load("reset", 0, 1'b0, 1'b0);
    check("reset_fault", 64'(o_fault), 64'(0));
    check("reset_halt", 64'(o_halt), 64'(0));

    // Two-word program ending in halt
    start_load();
    check_load("load_open", 0, 1'b0, 1'b1);
    send_word(32'h0001_1020);
    send_word(HALT);
    end_load();
    check_load("load2", model_wc, model_done, 1'b0);

    start_run();
    fetch(0, 1'b1);
    fetch(4, 1'b1);
    fetch(2, 1'b1);
    fetch(4 * CELDAS, 1'b1);
    fetch(0, 1'b1);
    fetch(4, 1'b0);
    fetch(7, 1'b0);
    fetch(4 * CELDAS + 8, 1'b0);
    fetch(4, 1'b1);
    random_fetches(20);
    fetch_end();

    // Full memory without a halt word, plus one surplus byte
    start_load();
    check_load("reload_open", 0, 1'b0, 1'b1);
    for (int k = 0; k < CELDAS; k++) begin
      w = $urandom();
      while (w == HALT) w = $urandom();
      send_word(w);
    end
    send_byte(8'h5A);
    end_load();
    check_load("full", model_wc, model_done, 1'b0);
    check("full_count_celdas", 64'(o_word_count), 64'(CELDAS));

    start_run();
    fetch(0, 1'b1);
    fetch(4 * (CELDAS - 1), 1'b1);
    random_fetches(40);
    fetch_end();

    // Restart after two bytes: the partial word must not leak into word 0
    start_load();
    send_byte(8'h12);
    send_byte(8'h34);
    start_load();
    send_word(32'hABCD_EF01);
    send_word(HALT);
    end_load();
    check_load("restart", model_wc, model_done, 1'b0);
    start_run();
    fetch(0, 1'b1);
    fetch(4, 1'b1);
    fetch(8, 1'b1);
    fetch_end();

    // Reset mid-run forces idle outputs; memory contents survive
    start_run();
    fetch(8, 1'b1);
    fetch_end();
    @(negedge i_clk);
    i_reset_n = 1'b0;
    #1;
    model_reset_outputs();
    check_load("midrun_reset", 0, 1'b0, 1'b0);
    check("midrun_reset_fault", 64'(o_fault), 64'(0));
    @(negedge i_clk);
    i_reset_n = 1'b1;
    start_run();
    fetch(0, 1'b1);
    fetch(12, 1'b1);
    fetch_end();

    @(negedge i_clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
